ec_prod_sum_array: RTL
======================

EC_PROD_SUM_ARRAY -- requirements
Module: ec_prod_sum_array

Interface
REQ-001 Parameter NUM_DIGITS, default 10: number of RNS digit channels.
REQ-002 Parameter DIG_WIDTH, default 18: bits per residue digit.
REQ-003 Parameter MODULI, default {262103,262079,262069,262051,262049,262027,177147,117649,78125,65536}: packed NUM_DIGITS*DIG_WIDTH vector, digit 0 in the LSBs, each modulus < 2^DIG_WIDTH.
REQ-004 Parameter PIPE_LAT, default 7, minimum 2: product-reduction pipeline depth in cycles.
REQ-005 Parameter CNT_WIDTH, default 16: term-counter width.
REQ-006 clk  in  1  clock; all logic rising-edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 clear  in  1  synchronous abort; zeroes accumulators and returns to IDLE.
REQ-009 in_valid  in  1  operand pair valid.
REQ-010 in_ready  out  1  block accepts operands.
REQ-011 in_last  in  1  marks final term of the current dot product.
REQ-012 dig_a  in  NUM_DIGITS*DIG_WIDTH  operand A residues, each < its modulus.
REQ-013 dig_b  in  NUM_DIGITS*DIG_WIDTH  operand B residues, each < its modulus.
REQ-014 out_valid  out  1  result digits valid.
REQ-015 out_ready  in  1  consumer accepts result.
REQ-016 dig_sum  out  NUM_DIGITS*DIG_WIDTH  per-digit sum of products mod modulus.
REQ-017 term_count  out  CNT_WIDTH  terms in the held result; saturates at all-ones.

Function
REQ-018 Per digit i: dig_sum[i] = (sum over terms of a[i]*b[i]) mod MODULI[i]; every stored value stays < MODULI[i].
REQ-019 Products are reduced in a feed-forward pipeline of exactly PIPE_LAT stages; the accumulator adds each reduced product with one conditional subtract per cycle.
REQ-020 A term transfers when in_valid && in_ready; one term may be accepted per cycle.
REQ-021 FSM states IDLE, ACCUM, FLUSH, HOLD; IDLE->ACCUM on the first transfer without in_last; IDLE or ACCUM->FLUSH on a transfer with in_last.
REQ-022 FLUSH counts PIPE_LAT cycles, then moves to HOLD.
REQ-023 HOLD->IDLE on out_valid && out_ready; accumulators and term counter clear in the same cycle.
REQ-024 in_ready = 1 in IDLE and ACCUM, 0 in FLUSH and HOLD.
REQ-025 out_valid = 1 only in HOLD; dig_sum and term_count are stable while out_valid && !out_ready.
REQ-026 Latency: a last term accepted at cycle t gives out_valid at t+PIPE_LAT+1.
REQ-027 clear overrides everything except reset: pipeline valid bits drop, in-flight terms are discarded, out_valid is 0 the next cycle.
REQ-028 in_valid while in_ready = 0 is ignored; no operand is lost or double-counted.

Reset
REQ-029 After reset: state IDLE, out_valid=0, in_ready=1, dig_sum=0, term_count=0, pipeline valid bits 0; a reset mid-operation discards all in-flight work.

Configuration
REQ-030 With EC_PROD_SUM_ERRINJ_EN defined, add inputs err_inj (1) and err_inj_digit ($clog2(NUM_DIGITS)); while err_inj=1 in HOLD, the LSB of the selected output digit is inverted, and internal state is unaffected.
REQ-031 Without EC_PROD_SUM_ERRINJ_EN, those ports do not exist and dig_sum is never altered.

Structure
REQ-032 Package ec_prod_sum_pkg holds the FSM state enum, default MODULI constant and digit-slice helper.
REQ-033 Sub-module rns_digit_mac (one digit: reduction pipeline plus accumulator) is instantiated NUM_DIGITS times by a generate loop; FSM and counters are shared.

Verification
REQ-034 Single term a=3,b=5 all digits, in_last=1 -> out_valid 8 cycles later (PIPE_LAT=7), dig_sum=15 all digits, term_count=1.
REQ-035 Wrap: digit1 a=b=78124 over three terms -> digit1=3; digit0 a=b=65535 over one term -> digit0=1.
REQ-036 Backpressure: out_ready=0 for 20 cycles in HOLD -> dig_sum stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-037 clear during FLUSH after 4 terms -> out_valid never rises; the next 1-term op returns only its own product.
REQ-038 Back-to-back ops: 100 random terms against a reference model, with random in_valid/out_ready gaps -> all digits match and term_count=100.
REQ-039 Macro on: err_inj=1, err_inj_digit=2, result 15 -> digit2=14 and other digits 15; err_inj=0 -> digit2=15.

Source files
------------

// File: rtl/ec_prod_sum_pkg.sv
// Shared types and constants for the RNS sum-of-products array.
// Holds the controller state enum, the default modulus set and a digit-slice helper.
package ec_prod_sum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int DEF_NUM_DIGITS = 10;
    localparam int DEF_DIG_WIDTH  = 18;
    localparam int MAX_VEC        = 1024;

    localparam logic [DEF_NUM_DIGITS*DEF_DIG_WIDTH-1:0] DEF_MODULI = {
        18'd262103, 18'd262079, 18'd262069, 18'd262051, 18'd262049,
        18'd262027, 18'd177147, 18'd117649, 18'd78125,  18'd65536
    };

    // Extract digit idx of width w from a packed vector (digit 0 in the LSBs).
    function automatic logic [31:0] digit_of(input logic [MAX_VEC-1:0] vec,
                                             input int unsigned idx,
                                             input int unsigned w);
        logic [MAX_VEC-1:0] s;
        s = vec >> (idx * w);
        return s[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/ec_prod_sum_array_mac.sv
// One RNS digit channel: feed-forward product reduction pipeline of PIPE_LAT
// stages followed by a modular accumulator with a single conditional subtract.
module rns_digit_mac #(
    parameter int                   DIG_WIDTH = 18,
    parameter int                   PIPE_LAT  = 7,
    parameter logic [DIG_WIDTH-1:0] MODULUS   = 18'd65536
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 in_fire,
    input  logic                 acc_clr,
    input  logic [DIG_WIDTH-1:0] a,
    input  logic [DIG_WIDTH-1:0] b,
    output logic [DIG_WIDTH-1:0] acc
);

    localparam int              PW    = 2 * DIG_WIDTH;
    localparam logic [PW-1:0]   MOD_P = PW'(MODULUS);

    logic [PIPE_LAT-1:0]  vld_q;
    logic [PW-1:0]        prod_q;
    logic [DIG_WIDTH-1:0] red_q [1:PIPE_LAT-1];
    logic [DIG_WIDTH-1:0] acc_q, acc_d;
    logic [DIG_WIDTH:0]   acc_sum;

    // Both addends are below MODULUS, so one subtract keeps the result in range.
    always_comb begin
        acc_sum = {1'b0, acc_q} + {1'b0, red_q[PIPE_LAT-1]};
        acc_d   = acc_q;
        if (vld_q[PIPE_LAT-1]) begin
            if (acc_sum >= {1'b0, MODULUS}) begin
                acc_d = DIG_WIDTH'(acc_sum - {1'b0, MODULUS});
            end else begin
                acc_d = acc_sum[DIG_WIDTH-1:0];
            end
        end
        if (clear || acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            vld_q <= '0;
            acc_q <= '0;
        end else begin
            vld_q <= {vld_q[PIPE_LAT-2:0], in_fire};
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk) begin
        prod_q   <= PW'(a) * PW'(b);
        red_q[1] <= DIG_WIDTH'(prod_q % MOD_P);
        for (int k = 2; k < PIPE_LAT; k++) begin
            red_q[k] <= red_q[k-1];
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ec_prod_sum_array.sv
// RNS dot-product engine: NUM_DIGITS digit MACs under one shared controller.
// Optional error injection on the held result when EC_PROD_SUM_ERRINJ_EN is defined.
module ec_prod_sum_array
    import ec_prod_sum_pkg::*;
#(
    parameter int                                NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int                                DIG_WIDTH  = DEF_DIG_WIDTH,
    parameter logic [NUM_DIGITS*DIG_WIDTH-1:0]   MODULI     = DEF_MODULI,
    parameter int                                PIPE_LAT   = 7,
    parameter int                                CNT_WIDTH  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [NUM_DIGITS*DIG_WIDTH-1:0] dig_a,
    input  logic [NUM_DIGITS*DIG_WIDTH-1:0] dig_b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_DIGITS*DIG_WIDTH-1:0] dig_sum,
    output logic [CNT_WIDTH-1:0]            term_count,
`ifdef EC_PROD_SUM_ERRINJ_EN
    input  logic                            err_inj,
    input  logic [$clog2(NUM_DIGITS)-1:0]   err_inj_digit,
`endif
    output state_e                          dbg_state
);

    // Handshakes: a term moves on in_valid && in_ready, a result on out_valid && out_ready;
    // neither valid may depend on its ready, and data is held while valid waits.

    localparam int VW  = NUM_DIGITS * DIG_WIDTH;
    localparam int FCW = $clog2(PIPE_LAT) + 1;

    state_e         state_q, state_d;
    logic [FCW-1:0] flush_q, flush_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic           xfer;
    logic           hold_done;
    logic [VW-1:0]  sum_raw;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);
    assign xfer      = in_valid && in_ready && !clear;
    assign hold_done = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        flush_d = '0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = in_last ? ST_FLUSH : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (xfer && in_last) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_q == FCW'(PIPE_LAT - 1)) begin
                    state_d = ST_HOLD;
                end else begin
                    flush_d = flush_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (hold_done) begin
            cnt_d = '0;
        end else if (xfer && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clear) begin
            state_d = ST_IDLE;
            flush_d = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            flush_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        localparam logic [DIG_WIDTH-1:0] MOD_G =
            DIG_WIDTH'(digit_of(MAX_VEC'(MODULI), g, DIG_WIDTH));
        rns_digit_mac #(
            .DIG_WIDTH (DIG_WIDTH),
            .PIPE_LAT  (PIPE_LAT),
            .MODULUS   (MOD_G)
        ) u_mac (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .in_fire (xfer),
            .acc_clr (hold_done),
            .a       (dig_a[g*DIG_WIDTH +: DIG_WIDTH]),
            .b       (dig_b[g*DIG_WIDTH +: DIG_WIDTH]),
            .acc     (sum_raw[g*DIG_WIDTH +: DIG_WIDTH])
        );
    end

`ifdef EC_PROD_SUM_ERRINJ_EN
    logic [VW-1:0] inj_mask;
    always_comb begin
        inj_mask = '0;
        if (err_inj && out_valid && (int'(err_inj_digit) < NUM_DIGITS)) begin
            inj_mask[int'(err_inj_digit) * DIG_WIDTH] = 1'b1;
        end
    end
    assign dig_sum = sum_raw ^ inj_mask;
`else
    assign dig_sum = sum_raw;
`endif

    assign term_count = cnt_q;
    assign dbg_state  = state_q;

endmodule
